iter_div: RTL and testbench

- Parametrised multi-cycle unsigned divider; successor to the 8-bit start/clk-driven invert unit.
- Generalised in width; adds a reciprocal mode, a start/busy/done handshake, divide-by-zero detection and reset.
- Restoring division, one quotient bit per clock.
- Used wherever the datapath needs a quotient/remainder or a reciprocal without a combinational divider.

---
 rtl/iter_div_pkg.sv | 12 +
 rtl/iter_div_step.sv | 21 ++
 rtl/iter_div.sv | 141 ++++++++++++++
 tb/tb_iter_div.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package iter_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module iter_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_o
);

  // One extra bit so the shifted partial remainder cannot overflow before the compare.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {r_i, bit_i};
    q_o     = (shifted >= {1'b0, d_i});
    r_o     = q_o ? WIDTH'(shifted - {1'b0, d_i}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle unsigned divider, one quotient bit per clock, with reciprocal mode.
// Optional macro ITER_DIV_EARLY_EXIT_EN resolves N < D in a single cycle.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             recip,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fast_q, fast_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] n_acc;
  logic [WIDTH-1:0] r_nxt;
  logic             q_bit;

  assign n_acc = recip ? '1 : num;

  iter_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i  (r_q),
    .bit_i(n_q[WIDTH-1]),
    .d_i  (d_q),
    .r_o  (r_nxt),
    .q_o  (q_bit)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    fast_d  = fast_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_acc;
          d_d     = den;
          r_d     = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          dz_d    = 1'b0;
          zero_d  = (den == '0);
          fast_d  = (den == '0);
`ifdef ITER_DIV_EARLY_EXIT_EN
          if ((den != '0) && (n_acc < den)) begin
            fast_d = 1'b1;
          end
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Short-circuit results spend one busy cycle here so done lands one edge after accept.
        if (fast_q) begin
          quot_d  = zero_q ? '1 : '0;
          rem_d   = n_q;
          dz_d    = zero_q;
          state_d = DONE;
        end else begin
          // Quotient bits shift into the vacated low end of the dividend register.
          n_d = {n_q[WIDTH-2:0], q_bit};
          r_d = r_nxt;
          if (cnt_q == '0) begin
            quot_d  = {n_q[WIDTH-2:0], q_bit};
            rem_d   = r_nxt;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      fast_q  <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      fast_q  <= fast_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_iter_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st8, rc8, busy8, done8, dz8;
  logic [7:0]  n8, d8, q8, r8;
  logic        st16, rc16, busy16, done16, dz16;
  logic [15:0] n16, d16, q16, r16;

  iter_div #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst(rst), .start(st8), .recip(rc8), .num(n8), .den(d8),
    .busy(busy8), .done(done8), .quot(q8), .rem(r8), .div_zero(dz8)
  );

  iter_div #(.WIDTH(16)) u_div16 (
    .clk(clk), .rst(rst), .start(st16), .recip(rc16), .num(n16), .den(d16),
    .busy(busy16), .done(done16), .quot(q16), .rem(r16), .div_zero(dz16)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned at;
  } exp_t;

  exp_t        sb8[$];
  exp_t        sb16[$];
  int unsigned cyc = 0;
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] last_q8 = '0, last_r8 = '0, last_q16 = '0, last_r16 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; zero divisor yields all-ones quotient and N as remainder.
  function automatic exp_t model(input int unsigned w, input logic rc, input logic [31:0] n,
                                 input logic [31:0] d, input int unsigned k);
    logic [31:0] mask, nn, dd;
    exp_t e;
    mask = (32'd1 << w) - 32'd1;
    nn   = rc ? mask : (n & mask);
    dd   = d & mask;
    e.dz = (dd == 0);
    if (dd == 0) begin
      e.q  = mask;
      e.r  = nn;
      e.at = k + 1;
    end else begin
      e.q  = nn / dd;
      e.r  = nn % dd;
      e.at = k + w;
`ifdef ITER_DIV_EARLY_EXIT_EN
      if (nn < dd) e.at = k + 1;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL done8_unexpected: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = sb8.pop_front();
        chk("quot8", q8, e.q);
        chk("rem8", r8, e.r);
        chk("div_zero8", dz8, e.dz);
        chk("done8_cycle", cyc, e.at);
        last_q8 = e.q;
        last_r8 = e.r;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done16 === 1'b1) begin
      if (sb16.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL done16_unexpected: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = sb16.pop_front();
        chk("quot16", q16, e.q);
        chk("rem16", r16, e.r);
        chk("div_zero16", dz16, e.dz);
        chk("done16_cycle", cyc, e.at);
        last_q16 = e.q;
        last_r16 = e.r;
      end
    end
  end

  task automatic wait_idle(input bit wide);
    int unsigned t;
    t = 0;
    @(negedge clk);
    while ((wide ? busy16 : busy8) !== 1'b0) begin
      t++;
      if (t > 100) begin
        nvec++; nerr++;
        $display("FAIL idle_timeout: got busy=1 expected idle within 100 cycles (wide=%0d)", wide);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Issues one request from IDLE; returns on the negedge right after the accepting edge.
  task automatic send(input bit wide, input logic rc, input logic [31:0] n, input logic [31:0] d);
    wait_idle(wide);
    if (wide) begin
      chk("hold_quot16", q16, last_q16);
      chk("hold_rem16", r16, last_r16);
      st16 = 1'b1; rc16 = rc; n16 = n[15:0]; d16 = d[15:0];
    end else begin
      chk("hold_quot8", q8, last_q8);
      chk("hold_rem8", r8, last_r8);
      st8 = 1'b1; rc8 = rc; n8 = n[7:0]; d8 = d[7:0];
    end
    @(negedge clk);
    if (wide) begin
      sb16.push_back(model(16, rc, n, d, cyc));
      chk("busy16_after_accept", busy16, 1);
      st16 = 1'b0; rc16 = 1'($urandom); n16 = 16'($urandom); d16 = 16'($urandom);
    end else begin
      sb8.push_back(model(8, rc, n, d, cyc));
      chk("busy8_after_accept", busy8, 1);
      st8 = 1'b0; rc8 = 1'($urandom); n8 = 8'($urandom); d8 = 8'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rn, rd;
    int unsigned t;
    rst = 1'b1;
    st8 = 1'b0; rc8 = 1'b0; n8 = '0; d8 = '0;
    st16 = 1'b0; rc16 = 1'b0; n16 = '0; d16 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy8", busy8, 0);
    chk("reset_done8", done8, 0);
    chk("reset_quot8", q8, 0);
    chk("reset_rem8", r8, 0);
    chk("reset_dz8", dz8, 0);
    chk("reset_busy16", busy16, 0);
    rst = 1'b0;

    send(0, 0, 100, 7);
    send(0, 1, 8'h55, 8);
    send(0, 0, 42, 0);
    send(0, 0, 42, 6);

    // A start while busy must be dropped.
    send(0, 0, 200, 3);
    repeat (2) @(negedge clk);
    st8 = 1'b1; rc8 = 1'b0; n8 = 9; d8 = 9;
    @(negedge clk);
    st8 = 1'b0;

    // Reset mid-operation discards the result.
    wait_idle(0);
    st8 = 1'b1; rc8 = 1'b0; n8 = 100; d8 = 7;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy8", busy8, 0);
    chk("midrst_done8", done8, 0);
    chk("midrst_quot8", q8, 0);
    chk("midrst_rem8", r8, 0);
    last_q8 = '0; last_r8 = '0;
    repeat (12) @(negedge clk);

    send(0, 0, 50, 5);
    send(0, 0, 5, 9);
    send(0, 0, 0, 13);
    send(0, 0, 201, 1);
    send(0, 0, 255, 255);
    send(0, 0, 254, 255);
    send(0, 1, 0, 1);

    for (int i = 0; i < 40; i++) begin
      rn = $urandom;
      rd = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
      send(0, ($urandom_range(0, 3) == 0), rn, rd);
    end

    send(1, 1, 0, 255);
    send(1, 0, 16'hFFFF, 16'h0100);
    send(1, 0, 1234, 0);
    for (int i = 0; i < 10; i++) begin
      rn = $urandom;
      rd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      send(1, ($urandom_range(0, 3) == 0), rn, rd);
    end

    t = 0;
    while ((sb8.size() != 0 || sb16.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb8.size() != 0 || sb16.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb8.size() + sb16.size());
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
